// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: a shift register of in-flight destination tags resolves forward selects and load-use stalls at decode.
// Latency: stall is combinational from ID inputs and scoreboard state; ex_valid/ex_fwd_sel are registered, 1 cycle after ID.
// Backpressure: hold freezes every register; stall asks ID/IF to repeat the current instruction while a bubble enters EX.
// Optional: define FWD_ZERO_REG_EN to treat register 0 as hardwired zero (never forwarded, never stalls).
module fwd_scoreboard #(
    parameter int REG_ADDR_W = 2,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_en,
    input  logic [REG_ADDR_W-1:0]         id_dst,
    input  logic                          id_reg_write,
    input  logic                          id_is_load,
    input  logic                          flush,
    input  logic                          hold,
    output logic                          stall,
    output logic                          ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel
);

    // One tracked instruction: entry 0 sits in EX, entry j sits j stages after EX.
    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic                  ld;
        logic [REG_ADDR_W-1:0] dst;
    } ent_t;

    ent_t                       r_sb [FWD_STAGES];
    logic [NUM_SRC*SEL_W-1:0]   r_fwd_sel;

    logic [NUM_SRC*SEL_W-1:0]   w_sel;
    logic                       w_ld_hit;
    logic                       w_load;
    logic                       w_dst_wr;
    logic                       w_src_ok;
    logic [REG_ADDR_W-1:0]      w_src;

    // Decode compare. Entry j will be in stage j+1 when the ID instruction reaches EX,
    // so a hit on entry j forwards from stage j+1. Once an instruction has moved past
    // the tracked window its result is already in the write-through register file.
    // Scanning from oldest to youngest lets the youngest producer win.
    always_comb begin
        w_sel    = '0;
        w_ld_hit = 1'b0;
        w_src    = '0;
        w_src_ok = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src = id_src[i*REG_ADDR_W +: REG_ADDR_W];
`ifdef FWD_ZERO_REG_EN
            w_src_ok = id_src_en[i] && (w_src != '0);
`else
            w_src_ok = id_src_en[i];
`endif
            if (w_src_ok) begin
                for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                    if (r_sb[j].vld && r_sb[j].wr && (r_sb[j].dst == w_src)) begin
                        w_sel[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
                    end
                end
                // A load still in EX has no data yet: the consumer must wait one cycle.
                if (r_sb[0].vld && r_sb[0].wr && r_sb[0].ld && (r_sb[0].dst == w_src)) begin
                    w_ld_hit = 1'b1;
                end
            end
        end
    end

    // Stall and admission; flush overrides stall so a killed instruction never stalls.
    always_comb begin
        stall  = id_valid && !flush && w_ld_hit;
        w_load = id_valid && !stall && !flush;
`ifdef FWD_ZERO_REG_EN
        w_dst_wr = id_reg_write && (id_dst != '0);
`else
        w_dst_wr = id_reg_write;
`endif
    end

    // Scoreboard shift and EX select register; hold freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FWD_STAGES; j++) begin
                r_sb[j] <= '0;
            end
            r_fwd_sel <= '0;
        end else if (!hold) begin
            for (int j = 1; j < FWD_STAGES; j++) begin
                r_sb[j] <= r_sb[j-1];
            end
            if (w_load) begin
                r_sb[0]   <= '{vld: 1'b1, wr: w_dst_wr, ld: id_is_load, dst: id_dst};
                r_fwd_sel <= w_sel;
            end else begin
                r_sb[0]   <= '0;
                r_fwd_sel <= '0;
            end
        end
    end

    assign ex_valid   = r_sb[0].vld;
    assign ex_fwd_sel = r_fwd_sel;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard with default parameters (2 regs bits, 2 operands, 2 forwarding stages).
// Stimulus queues the hand-derived EX content for every clock edge; a monitor compares it after each edge.
// stall and asynchronous reset are checked directly by the stimulus process.
module tb_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_src;
    logic [1:0] id_src_en;
    logic [1:0] id_dst;
    logic       id_reg_write;
    logic       id_is_load;
    logic       flush;
    logic       hold;
    logic       stall;
    logic       ex_valid;
    logic [3:0] ex_fwd_sel;

    typedef struct {
        logic       vld;
        logic [3:0] sel;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fwd_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_en    (id_src_en),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .hold         (hold),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_fwd_sel   (ex_fwd_sel)
    );

    always #5 clk = ~clk;

    // Drive one ID cycle, check stall, queue the EX content expected after the edge.
    task automatic ins(input string tag, input logic v, input logic [1:0] s0, input logic [1:0] s1,
                       input logic [1:0] en, input logic [1:0] d, input logic wr, input logic ld,
                       input logic fl, input logic hd, input logic est,
                       input logic evld, input logic [1:0] e0, input logic [1:0] e1);
        exp_t e;
        id_valid     = v;
        id_src       = {s1, s0};
        id_src_en    = en;
        id_dst       = d;
        id_reg_write = wr;
        id_is_load   = ld;
        flush        = fl;
        hold         = hd;
        #1;
        n_checks++;
        if (stall !== est) begin
            n_errors++;
            $display("FAIL %s stall: got %b, required %b", tag, stall, est);
        end
        e.vld = evld;
        e.sel = {e1, e0};
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        n_checks++;
        if (ex_valid !== 1'b0 || ex_fwd_sel !== 4'h0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: ex_valid=%b ex_fwd_sel=%h stall=%b, required 0 0 0",
                     tag, ex_valid, ex_fwd_sel, stall);
        end
    endtask

    // Monitor: after every edge taken out of reset, the EX register must match the next queued entry.
    initial begin
        logic took;
        exp_t e;
        forever begin
            @(posedge clk);
            took = rst_n;
            @(negedge clk);
            if (took) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL ex_unexpected: ex_valid=%b ex_fwd_sel=%h, required no edge", ex_valid, ex_fwd_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (ex_valid !== e.vld || ex_fwd_sel !== e.sel) begin
                        n_errors++;
                        $display("FAIL %s ex: ex_valid=%b ex_fwd_sel=%h, required ex_valid=%b ex_fwd_sel=%h",
                                 e.tag, ex_valid, ex_fwd_sel, e.vld, e.sel);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] zr_sel;
`ifdef FWD_ZERO_REG_EN
        zr_sel = 2'd0;
`else
        zr_sel = 2'd1;
`endif
        rst_n = 1'b0;
        id_valid = 1'b0; id_src = '0; id_src_en = '0; id_dst = '0;
        id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0; hold = 1'b0;
        #1;
        chk_rst("reset_init");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //  tag         v s0 s1 en    d wr ld fl hd  st  vld e0 e1
        ins("i1",       1, 0, 0, 2'b00, 1, 1, 0, 0, 0,  0,  1, 0, 0);
        ins("b2b_1",    1, 1, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 1, 0);
        ins("b2b_2",    1, 1, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 2, 0);
        ins("b2b_3",    1, 1, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 0, 0);
        ins("pri_a",    1, 0, 0, 2'b00, 2, 1, 0, 0, 0,  0,  1, 0, 0);
        ins("pri_b",    1, 0, 0, 2'b00, 2, 1, 0, 0, 0,  0,  1, 0, 0);
        ins("pri_use",  1, 0, 2, 2'b10, 0, 0, 0, 0, 0,  0,  1, 0, 1);
        ins("ld",       1, 0, 0, 2'b00, 3, 1, 1, 0, 0,  0,  1, 0, 0);
        ins("lu_stall", 1, 3, 0, 2'b01, 0, 0, 0, 0, 0,  1,  0, 0, 0);
        ins("lu_use",   1, 3, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 2, 0);
        ins("h_a",      1, 0, 0, 2'b00, 1, 1, 0, 0, 0,  0,  1, 0, 0);
        ins("h_b",      1, 1, 0, 2'b01, 2, 1, 0, 0, 0,  0,  1, 1, 0);
        ins("hold_1",   1, 0, 1, 2'b10, 0, 0, 0, 0, 1,  0,  1, 1, 0);
        ins("hold_2",   1, 0, 1, 2'b10, 0, 0, 0, 0, 1,  0,  1, 1, 0);
        ins("hold_3",   1, 0, 1, 2'b10, 0, 0, 0, 0, 1,  0,  1, 1, 0);
        ins("h_rel",    1, 2, 1, 2'b11, 0, 0, 0, 0, 0,  0,  1, 1, 2);
        ins("ld2",      1, 0, 0, 2'b00, 3, 1, 1, 0, 0,  0,  1, 0, 0);
        ins("flush",    1, 3, 0, 2'b01, 0, 0, 0, 1, 0,  0,  0, 0, 0);
        ins("en_off",   1, 3, 0, 2'b00, 1, 0, 0, 0, 0,  0,  1, 0, 0);
        ins("no_wr",    1, 1, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 0, 0);
        ins("r0_def",   1, 0, 0, 2'b00, 0, 1, 0, 0, 0,  0,  1, 0, 0);
        ins("r0_use",   1, 0, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, zr_sel, 0);
        ins("idle",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0,  0, 0, 0);
        ins("ld3",      1, 0, 0, 2'b00, 3, 1, 1, 0, 0,  0,  1, 0, 0);
        ins("hold_st",  1, 3, 0, 2'b01, 0, 0, 0, 0, 1,  1,  1, 0, 0);
        ins("lu2_st",   1, 3, 0, 2'b01, 0, 0, 0, 0, 0,  1,  0, 0, 0);
        ins("lu2_use",  1, 3, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 2, 0);
        ins("pre_rst",  1, 0, 0, 2'b00, 1, 1, 1, 0, 0,  0,  1, 0, 0);

        // Mid-stream reset: a load to R1 sits in EX and ID reads R1, which would stall.
        @(negedge clk);
        #1;
        id_valid = 1'b1; id_src = 4'b0001; id_src_en = 2'b01; id_dst = 2'd0;
        id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0; hold = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_rst("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ins("post_rst", 1, 1, 0, 2'b01, 0, 0, 0, 0, 0,  0,  1, 0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected EX entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
